// File: rtl/multicycle_control_pkg.sv
// Shared constants for the multicycle RV32I control path: state encoding,
// opcodes, ALU op codes and datapath mux select codes.
package multicycle_control_pkg;

    // FSM state encoding (4 bits, also exported on the debug state port)
    localparam logic [3:0] StFetch   = 4'd0;
    localparam logic [3:0] StDecode  = 4'd1;
    localparam logic [3:0] StExecR   = 4'd2;
    localparam logic [3:0] StExecI   = 4'd3;
    localparam logic [3:0] StMemAddr = 4'd4;
    localparam logic [3:0] StMemRd   = 4'd5;
    localparam logic [3:0] StMemWb   = 4'd6;
    localparam logic [3:0] StMemWr   = 4'd7;
    localparam logic [3:0] StRWb     = 4'd8;
    localparam logic [3:0] StBranch  = 4'd9;
    localparam logic [3:0] StJal     = 4'd10;
    localparam logic [3:0] StHalt    = 4'd11;

    // Major opcodes
    localparam logic [6:0] OpcR      = 7'b0110011;
    localparam logic [6:0] OpcI      = 7'b0010011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcJal    = 7'b1101111;

    // ALU op codes understood by the ALU control port
    localparam logic [4:0] OpAnd = 5'd0;
    localparam logic [4:0] OpOr  = 5'd1;
    localparam logic [4:0] OpAdd = 5'd2;
    localparam logic [4:0] OpSub = 5'd6;
    localparam logic [4:0] OpSlt = 5'd7;

    // Mux select codes
    localparam logic [1:0] SrcAPc    = 2'd0;
    localparam logic [1:0] SrcAOldPc = 2'd1;
    localparam logic [1:0] SrcARs1   = 2'd2;
    localparam logic [1:0] SrcBReg   = 2'd0;
    localparam logic [1:0] SrcBFour  = 2'd1;
    localparam logic [1:0] SrcBImm   = 2'd2;
    localparam logic [1:0] WbAluOut  = 2'd0;
    localparam logic [1:0] WbMdr     = 2'd1;
    localparam logic [1:0] WbPc      = 2'd2;

    typedef enum logic [1:0] {ClsR, ClsI, ClsOther} op_class_e;

    // Classify an opcode for the ALU op decoder
    function automatic op_class_e op_class(input logic [6:0] opc);
        if (opc == OpcR) return ClsR;
        if (opc == OpcI) return ClsI;
        return ClsOther;
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control-to-datapath bundle: IR/Zero in, ALU control and strobes out.
interface multicycle_control_if #(
    parameter int unsigned CntW = 32
);
    logic [31:0]     instr;
    logic            zero;
    logic [4:0]      alu_control;
    logic [1:0]      alu_src_a;
    logic [1:0]      alu_src_b;
    logic            iord;
    logic            mem_read;
    logic            mem_write;
    logic            ir_write;
    logic            pc_write;
    logic            pc_source;
    logic            reg_write;
    logic [1:0]      memto_reg;
    logic            illegal;
    logic            halted;
    logic [3:0]      state;
    logic [CntW-1:0] instr_count;

    // Control block side
    modport master (
        input  instr, zero,
        output alu_control, alu_src_a, alu_src_b, iord, mem_read, mem_write, ir_write,
               pc_write, pc_source, reg_write, memto_reg, illegal, halted, state, instr_count
    );

    // Datapath side
    modport slave (
        output instr, zero,
        input  alu_control, alu_src_a, alu_src_b, iord, mem_read, mem_write, ir_write,
               pc_write, pc_source, reg_write, memto_reg, illegal, halted, state, instr_count
    );
endinterface

// File: rtl/multicycle_control_alu_op_decoder.sv
// Maps {opcode class, funct3, funct7} to an ALU op and a legality flag.
module alu_op_decoder
    import multicycle_control_pkg::*;
(
    input  op_class_e  cls_i,
    input  logic [2:0] funct3_i,
    input  logic [6:0] funct7_i,
    output logic [4:0] alu_op_o,
    output logic       valid_o
);

    // Decode funct fields; non-ALU classes always use add and are legal here
    always_comb begin
        alu_op_o = OpAdd;
        valid_o  = 1'b0;
        case (cls_i)
            ClsR: begin
                if (funct7_i == 7'h00) begin
                    valid_o = 1'b1;
                    case (funct3_i)
                        3'b000:  alu_op_o = OpAdd;
                        3'b111:  alu_op_o = OpAnd;
                        3'b110:  alu_op_o = OpOr;
                        3'b010:  alu_op_o = OpSlt;
                        default: valid_o  = 1'b0;
                    endcase
                end else if (funct7_i == 7'h20 && funct3_i == 3'b000) begin
                    valid_o  = 1'b1;
                    alu_op_o = OpSub;
                end
            end
            ClsI: begin
                valid_o = 1'b1;
                case (funct3_i)
                    3'b000:  alu_op_o = OpAdd;
                    3'b111:  alu_op_o = OpAnd;
                    3'b110:  alu_op_o = OpOr;
                    3'b010:  alu_op_o = OpSlt;
                    default: valid_o  = 1'b0;
                endcase
            end
            default: begin
                valid_o  = 1'b1;
                alu_op_o = OpAdd;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle RV32I datapath.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int unsigned CntW        = 32,
    parameter bit          IllegalTrap = 1'b0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    multicycle_control_if.master ctrl_io
);

    logic [3:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [6:0]      opcode;
    logic            opc_known;
    logic            legal;
    logic            retire;
    logic [4:0]      dec_op;
    logic            dec_valid;

    assign opcode    = ctrl_io.instr[6:0];
    assign opc_known = (opcode == OpcR) || (opcode == OpcI) || (opcode == OpcLoad) ||
                       (opcode == OpcStore) || (opcode == OpcBranch) || (opcode == OpcJal);
    assign legal     = opc_known && dec_valid;

    alu_op_decoder u_dec (
        .cls_i    (op_class(opcode)),
        .funct3_i (ctrl_io.instr[14:12]),
        .funct7_i (ctrl_io.instr[31:25]),
        .alu_op_o (dec_op),
        .valid_o  (dec_valid)
    );

    // Next-state sequencing and retire detection
    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            StFetch:  state_d = StDecode;
            StDecode: begin
                if (!legal) begin
                    state_d = IllegalTrap ? StHalt : StFetch;
                end else begin
                    case (opcode)
                        OpcR:                state_d = StExecR;
                        OpcI:                state_d = StExecI;
                        OpcLoad, OpcStore:   state_d = StMemAddr;
                        OpcBranch:           state_d = StBranch;
                        default:             state_d = StJal;
                    endcase
                end
            end
            StExecR, StExecI: state_d = StRWb;
            StMemAddr: state_d = (opcode == OpcStore) ? StMemWr : StMemRd;
            StMemRd:   state_d = StMemWb;
            StMemWb, StMemWr, StRWb, StBranch, StJal: begin
                state_d = StFetch;
                retire  = 1'b1;
            end
            StHalt:    state_d = StHalt;
            default:   state_d = StFetch;
        endcase
        cnt_d = retire ? cnt_q + 1'b1 : cnt_q;
    end

    // State and retired-instruction counter
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StFetch;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Output decode; reset overrides so nothing strobes while rst_i is high
    always_comb begin
        ctrl_io.alu_control = 5'd0;
        ctrl_io.alu_src_a   = SrcAPc;
        ctrl_io.alu_src_b   = SrcBReg;
        ctrl_io.iord        = 1'b0;
        ctrl_io.mem_read    = 1'b0;
        ctrl_io.mem_write   = 1'b0;
        ctrl_io.ir_write    = 1'b0;
        ctrl_io.pc_write    = 1'b0;
        ctrl_io.pc_source   = 1'b0;
        ctrl_io.reg_write   = 1'b0;
        ctrl_io.memto_reg   = WbAluOut;
        ctrl_io.illegal     = 1'b0;
        ctrl_io.halted      = 1'b0;
        if (rst_i) begin
            ctrl_io.alu_control = OpAdd;
        end else begin
            case (state_q)
                StFetch: begin
                    ctrl_io.mem_read    = 1'b1;
                    ctrl_io.ir_write    = 1'b1;
                    ctrl_io.alu_src_b   = SrcBFour;
                    ctrl_io.alu_control = OpAdd;
                    ctrl_io.pc_write    = 1'b1;
                end
                StDecode: begin
                    ctrl_io.alu_src_a   = SrcAOldPc;
                    ctrl_io.alu_src_b   = SrcBImm;
                    ctrl_io.alu_control = OpAdd;
                    ctrl_io.illegal     = !legal;
                end
                StExecR: begin
                    ctrl_io.alu_src_a   = SrcARs1;
                    ctrl_io.alu_control = dec_op;
                end
                StExecI: begin
                    ctrl_io.alu_src_a   = SrcARs1;
                    ctrl_io.alu_src_b   = SrcBImm;
                    ctrl_io.alu_control = dec_op;
                end
                StRWb:   ctrl_io.reg_write = 1'b1;
                StMemAddr: begin
                    ctrl_io.alu_src_a   = SrcARs1;
                    ctrl_io.alu_src_b   = SrcBImm;
                    ctrl_io.alu_control = OpAdd;
                end
                StMemRd: begin
                    ctrl_io.mem_read = 1'b1;
                    ctrl_io.iord     = 1'b1;
                end
                StMemWb: begin
                    ctrl_io.reg_write = 1'b1;
                    ctrl_io.memto_reg = WbMdr;
                end
                StMemWr: begin
                    ctrl_io.mem_write = 1'b1;
                    ctrl_io.iord      = 1'b1;
                end
                StBranch: begin
                    ctrl_io.alu_src_a   = SrcARs1;
                    ctrl_io.alu_control = OpSub;
                    ctrl_io.pc_source   = 1'b1;
                    ctrl_io.pc_write    = ctrl_io.zero;
                end
                StJal: begin
                    ctrl_io.reg_write = 1'b1;
                    ctrl_io.memto_reg = WbPc;
                    ctrl_io.pc_write  = 1'b1;
                    ctrl_io.pc_source = 1'b1;
                end
                StHalt:  ctrl_io.halted = 1'b1;
                default: ;
            endcase
        end
    end

    assign ctrl_io.state       = state_q;
    assign ctrl_io.instr_count = cnt_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench: per-instruction expected output sequences built from the
// instruction's format, compared cycle by cycle against the control block.
module tb_multicycle_control;
    import multicycle_control_pkg::*;

    localparam int KAnd = int'(OpAnd);
    localparam int KOr  = int'(OpOr);
    localparam int KAdd = int'(OpAdd);
    localparam int KSub = int'(OpSub);
    localparam int KSlt = int'(OpSlt);

    logic clk = 1'b0;
    logic rst0, rst1;
    always #5 clk = ~clk;

    multicycle_control_if #(.CntW(32)) if0 ();
    multicycle_control_if #(.CntW(32)) if1 ();

    multicycle_control #(.CntW(32), .IllegalTrap(1'b0)) dut0 (
        .clk_i   (clk),
        .rst_i   (rst0),
        .ctrl_io (if0)
    );
    multicycle_control #(.CntW(32), .IllegalTrap(1'b1)) dut1 (
        .clk_i   (clk),
        .rst_i   (rst1),
        .ctrl_io (if1)
    );

    logic [19:0] ov0, ov1;
    assign ov0 = {if0.alu_control, if0.alu_src_a, if0.alu_src_b, if0.iord, if0.mem_read,
                  if0.mem_write, if0.ir_write, if0.pc_write, if0.pc_source, if0.reg_write,
                  if0.memto_reg, if0.illegal, if0.halted};
    assign ov1 = {if1.alu_control, if1.alu_src_a, if1.alu_src_b, if1.iord, if1.mem_read,
                  if1.mem_write, if1.ir_write, if1.pc_write, if1.pc_source, if1.reg_write,
                  if1.memto_reg, if1.illegal, if1.halted};

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_cnt = 32'd0;
    logic [19:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [19:0] vec(input int alu, input int sa, input int sb, input int iord,
                                        input int mr, input int mw, input int irw, input int pcw,
                                        input int pcs, input int rw, input int m2r, input int ill,
                                        input int hlt);
        logic [19:0] v;
        v = {alu[4:0], sa[1:0], sb[1:0], iord[0], mr[0], mw[0], irw[0], pcw[0], pcs[0], rw[0],
             m2r[1:0], ill[0], hlt[0]};
        return v;
    endfunction

    function automatic logic [19:0] fetch_vec();
        return vec(KAdd, 0, 1, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0);
    endfunction

    function automatic logic [19:0] reset_vec();
        return vec(KAdd, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    // Fill exp_q with one vector per cycle from FETCH to the last state; return 1 if it retires
    function automatic int model(input logic [31:0] ins, input logic z);
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        int         op;
        bit         ok;
        opc = ins[6:0];
        f3  = ins[14:12];
        f7  = ins[31:25];
        op  = KAdd;
        ok  = 1'b0;
        if (opc == 7'b0110011) begin
            if (f7 == 7'h00 && f3 == 3'b000) begin op = KAdd; ok = 1'b1; end
            if (f7 == 7'h20 && f3 == 3'b000) begin op = KSub; ok = 1'b1; end
            if (f7 == 7'h00 && f3 == 3'b111) begin op = KAnd; ok = 1'b1; end
            if (f7 == 7'h00 && f3 == 3'b110) begin op = KOr;  ok = 1'b1; end
            if (f7 == 7'h00 && f3 == 3'b010) begin op = KSlt; ok = 1'b1; end
        end else if (opc == 7'b0010011) begin
            if (f3 == 3'b000) begin op = KAdd; ok = 1'b1; end
            if (f3 == 3'b111) begin op = KAnd; ok = 1'b1; end
            if (f3 == 3'b110) begin op = KOr;  ok = 1'b1; end
            if (f3 == 3'b010) begin op = KSlt; ok = 1'b1; end
        end else begin
            ok = (opc == 7'b0000011) || (opc == 7'b0100011) || (opc == 7'b1100011) ||
                 (opc == 7'b1101111);
        end
        exp_q.delete();
        exp_q.push_back(fetch_vec());
        exp_q.push_back(vec(KAdd, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, ok ? 0 : 1, 0));
        if (!ok) return 0;
        case (opc)
            7'b0110011: begin
                exp_q.push_back(vec(op, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
                exp_q.push_back(vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
            end
            7'b0010011: begin
                exp_q.push_back(vec(op, 2, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
                exp_q.push_back(vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
            end
            7'b0000011: begin
                exp_q.push_back(vec(KAdd, 2, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
                exp_q.push_back(vec(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
                exp_q.push_back(vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
            end
            7'b0100011: begin
                exp_q.push_back(vec(KAdd, 2, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
                exp_q.push_back(vec(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
            end
            7'b1100011: exp_q.push_back(vec(KSub, 2, 0, 0, 0, 0, 0, int'(z), 1, 0, 0, 0, 0));
            default:    exp_q.push_back(vec(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 2, 0, 0));
        endcase
        return 1;
    endfunction

    // Run one instruction on dut0 starting just after the edge that entered FETCH
    task automatic run0(input logic [31:0] ins, input logic z, input string tag);
        int r;
        r = model(ins, z);
        if0.instr = ins;
        if0.zero  = z;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            check_eq($sformatf("%s_c%0d", tag, i), {44'd0, ov0}, {44'd0, exp_q[i]});
            @(posedge clk);
            #1;
        end
        exp_cnt = exp_cnt + r;
        check_eq({tag, "_cnt"}, {32'd0, if0.instr_count}, {32'd0, exp_cnt});
        check_eq({tag, "_lat"}, {60'd0, if0.state}, {60'd0, StFetch});
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int          k;
        w = $urandom();
        case ($urandom_range(0, 8))
            0: begin
                w[6:0] = 7'b0110011;
                k = $urandom_range(0, 4);
                w[31:25] = (k == 1) ? 7'h20 : 7'h00;
                case (k)
                    0, 1: w[14:12] = 3'b000;
                    2:    w[14:12] = 3'b111;
                    3:    w[14:12] = 3'b110;
                    default: w[14:12] = 3'b010;
                endcase
            end
            1: begin
                w[6:0] = 7'b0110011;
                if ($urandom_range(0, 1) == 1) w[31:25] = 7'h20;
            end
            2: w[6:0] = 7'b0010011;
            3: begin w[6:0] = 7'b0000011; w[14:12] = 3'b010; end
            4: begin w[6:0] = 7'b0100011; w[14:12] = 3'b010; end
            5: begin w[6:0] = 7'b1100011; w[14:12] = 3'b000; end
            6: w[6:0] = 7'b1101111;
            default: ;
        endcase
        return w;
    endfunction

    initial begin
        rst0 = 1'b1;
        rst1 = 1'b1;
        if0.instr = 32'h0000_0013;
        if0.zero  = 1'b0;
        if1.instr = 32'h0020_81B3;
        if1.zero  = 1'b0;
        #12;
        check_eq("rst_out", {44'd0, ov0}, {44'd0, reset_vec()});
        check_eq("rst_state", {60'd0, if0.state}, {60'd0, StFetch});
        check_eq("rst_cnt", {32'd0, if0.instr_count}, 64'd0);

        // Trapping instance: one add retires, then an all-ones word halts it
        @(posedge clk);
        #1 rst1 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_eq("t5_cnt1", {32'd0, if1.instr_count}, 64'd1);
        if1.instr = 32'hFFFF_FFFF;
        @(negedge clk);
        check_eq("t5_fetch", {44'd0, ov1}, {44'd0, fetch_vec()});
        @(negedge clk);
        check_eq("t5_illegal", {44'd0, ov1}, {44'd0, vec(KAdd, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0)});
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_eq($sformatf("t5_halt%0d", i), {44'd0, ov1},
                     {44'd0, vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)});
        end
        check_eq("t5_state", {60'd0, if1.state}, {60'd0, StHalt});
        #1 rst1 = 1'b1;
        #1;
        check_eq("t5_rst_cnt", {32'd0, if1.instr_count}, 64'd0);
        check_eq("t5_rst_state", {60'd0, if1.state}, {60'd0, StFetch});
        check_eq("t5_rst_out", {44'd0, ov1}, {44'd0, reset_vec()});
        @(posedge clk);
        #1 rst1 = 1'b0;
        @(negedge clk);
        check_eq("t5_refetch", {44'd0, ov1}, {44'd0, fetch_vec()});

        // Directed instructions on the non-trapping instance
        @(posedge clk);
        #1 rst0 = 1'b0;
        run0(32'h0020_81B3, 1'b0, "add");
        run0(32'h4020_81B3, 1'b0, "sub");
        run0(32'h0220_81B3, 1'b0, "sub_bad");
        run0(32'h0080_A283, 1'b0, "lw");
        run0(32'h0020_8863, 1'b1, "beq_t");
        run0(32'h0020_8863, 1'b0, "beq_n");
        run0(32'h0100_00EF, 1'b0, "jal");
        run0(32'h0050_E093, 1'b0, "ori");

        // Asynchronous reset while in MEM_WR
        if0.instr = 32'h0020_A423;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("t6_memwr", {63'd0, if0.mem_write}, 64'd1);
        #1 rst0 = 1'b1;
        #1;
        check_eq("t6_drop", {63'd0, if0.mem_write}, 64'd0);
        check_eq("t6_state", {60'd0, if0.state}, {60'd0, StFetch});
        check_eq("t6_cnt", {32'd0, if0.instr_count}, 64'd0);
        exp_cnt = 32'd0;
        @(posedge clk);
        #1 rst0 = 1'b0;

        for (int n = 0; n < 300; n++) begin
            run0(rand_instr(), 1'($urandom_range(0, 1)), $sformatf("rnd%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
